// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing, axis total helper and lock FSM state type
// shared by the sync decoder and its per-axis trackers.
package vga_pkg;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {ACQUIRE, VERIFY, LOCKED} lock_state_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_axis.sv
// vga_axis_tracker: one timing axis -- sync edge detect, reload/wrap counter and
// a free-run prediction of where the next sync edge should land.
module vga_axis_tracker
    import vga_pkg::*;
#(
    parameter int TOT    = 800,
    parameter int RELOAD = 656,
    parameter bit POL    = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_en,
    input  logic             i_advance,
    input  logic             i_sync,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic             o_edge,
    output logic             o_pred
);

    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_asserted;
    logic             w_wrap;
    logic [CNT_W-1:0] w_free;

    assign w_asserted = (i_sync == POL);
    assign w_wrap     = i_advance && (r_cnt == CNT_W'(TOT - 1));
    assign w_free     = !i_advance ? r_cnt : w_wrap ? '0 : r_cnt + CNT_W'(1);
    assign o_edge     = i_pix_en && w_asserted && !r_prev;
    // An edge is expected exactly when free-running would land on the reload point.
    assign o_pred     = i_advance && (w_free == CNT_W'(RELOAD));
    assign o_cnt_nxt  = o_edge ? CNT_W'(RELOAD) : w_free;
    assign o_cnt      = r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else if (i_pix_en) begin
            r_prev <= w_asserted;
            r_cnt  <= o_cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel column/line and active-video valid from received
// hsync/vsync, with a lock FSM that qualifies timing and flags sync disagreements.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_en,
    input  logic             i_hsync,
    input  logic             i_vsync,
    output logic [CNT_W-1:0] o_hdata,
    output logic [CNT_W-1:0] o_vdata,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_frame_start,
    output logic             o_sync_err
);

    localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int GW    = $clog2(LOCK_FRAMES + 1);

    if (H_TOT > 4095 || V_TOT > 4095) begin : g_tot_check
        $error("vga_sync_decoder: H_TOT/V_TOT exceed 12-bit counters");
    end

    lock_state_t      r_state;
    logic [GW-1:0]    r_good;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_h_wrap;
    logic             w_hs_edge;
    logic             w_hs_pred;
    logic             w_vs_edge;
    logic             w_vs_pred;
    logic             w_bad_edge;
    logic             w_miss;
    logic             w_drop;
    logic             w_good_vs;
    logic             w_gain;
    logic             w_lock_nxt;

    assign w_h_wrap = i_pix_en && (o_hdata == CNT_W'(H_TOT - 1));

    vga_axis_tracker #(.TOT(H_TOT), .RELOAD(H_ACTIVE + H_FP), .POL(HS_POL)) u_h (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_pix_en  (i_pix_en),
        .i_advance (i_pix_en),
        .i_sync    (i_hsync),
        .o_cnt     (o_hdata),
        .o_cnt_nxt (w_h_nxt),
        .o_edge    (w_hs_edge),
        .o_pred    (w_hs_pred)
    );

    // The line counter advances on the horizontal wrap; a vsync reload overrides it.
    vga_axis_tracker #(.TOT(V_TOT), .RELOAD(V_ACTIVE + V_FP), .POL(VS_POL)) u_v (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_pix_en  (i_pix_en),
        .i_advance (w_h_wrap),
        .i_sync    (i_vsync),
        .o_cnt     (o_vdata),
        .o_cnt_nxt (w_v_nxt),
        .o_edge    (w_vs_edge),
        .o_pred    (w_vs_pred)
    );

    assign w_bad_edge = (w_hs_edge && !w_hs_pred) || (w_vs_edge && !w_vs_pred);
    assign w_miss     = (w_hs_edge != w_hs_pred) || (w_vs_edge != w_vs_pred);
    assign w_drop     = (r_state == VERIFY && w_bad_edge) || (r_state == LOCKED && w_miss);
    assign w_good_vs  = (r_state == VERIFY) && !w_drop && w_vs_edge;
    assign w_gain     = w_good_vs && (r_good == GW'(LOCK_FRAMES - 1));
    assign w_lock_nxt = (r_state == LOCKED && !w_drop) || w_gain;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ACQUIRE;
            r_good        <= '0;
            o_valid       <= 1'b0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_sync_err    <= 1'b0;
        end else begin
            o_valid       <= w_lock_nxt && (w_h_nxt < CNT_W'(H_ACTIVE)) && (w_v_nxt < CNT_W'(V_ACTIVE));
            o_locked      <= w_lock_nxt;
            o_frame_start <= i_pix_en && w_lock_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
            o_sync_err    <= (r_state == LOCKED) && w_drop;
            case (r_state)
                ACQUIRE: begin
                    if (w_vs_edge) begin
                        r_state <= VERIFY;
                        r_good  <= '0;
                    end
                end
                VERIFY: begin
                    if (w_drop) r_state <= ACQUIRE;
                    else if (w_gain) r_state <= LOCKED;
                    if (w_good_vs) r_good <= r_good + GW'(1);
                end
                LOCKED: begin
                    if (w_drop) r_state <= ACQUIRE;
                end
                default: r_state <= ACQUIRE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed loopback bench; a reduced-size timing generator drives an
// active-low and an active-high decoder, checking recovered timing and lock behaviour.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HR = HA + HF;
    localparam int VR = VA + VF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        ha = 1'b0;
    logic        va = 1'b0;
    logic [11:0] hd0, vd0, hd1, vd1;
    logic        va0, lk0, fs0, er0, va1, lk1, fs1, er1;
    logic [27:0] v0, v1;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   gh = 5, gv = 3, sh = 5, sv = 3;
    int   vs_cnt = 0;
    int   shift_line = -1;
    logic vs_prev = 1'b0;
    logic chk = 1'b0;
    logic drop = 1'b0;
    logic ovr = 1'b0;
    logic ovr_hs = 1'b0;
    logic ovr_vs = 1'b0;

    always #5 clk = ~clk;

    assign v0 = {hd0, vd0, va0, fs0, er0, lk0};
    assign v1 = {hd1, vd1, va1, fs1, er1, lk1};

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_hsync(~ha), .i_vsync(~va),
        .o_hdata(hd0), .o_vdata(vd0), .o_valid(va0), .o_locked(lk0),
        .o_frame_start(fs0), .o_sync_err(er0)
    );

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_hsync(ha), .i_vsync(va),
        .o_hdata(hd1), .o_vdata(vd1), .o_valid(va1), .o_locked(lk1),
        .o_frame_start(fs1), .o_sync_err(er1)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: present the generator position (sync asserted flags), sample #1 after the edge.
    task automatic tick(input logic en);
        logic [27:0] e;
        int off;
        off = (gv == shift_line) ? 1 : 0;
        pix_en = en;
        ha = ovr ? ovr_hs : (gh >= HR + off) && (gh < HR + HS + off);
        va = ovr ? ovr_vs : !drop && (gv >= VR) && (gv < VR + VS);
        if (en) begin
            if (va && !vs_prev) vs_cnt++;
            vs_prev = va;
            sh = gh;
            sv = gv;
            if (gh == HT - 1) begin
                gh = 0;
                gv = (gv == VT - 1) ? 0 : gv + 1;
            end else begin
                gh++;
            end
        end
        @(posedge clk);
        #1;
        e = {12'(sh), 12'(sv), (sh < HA && sv < VA), (en && sh == 0 && sv == 0), 1'b0, 1'b1};
        if (chk) check("track", {v0, v1}, {e, e});
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 4 * HT * VT && !(gh == h && gv == v); i++) tick(1'b1);
    endtask

    task automatic relock();
        chk = 1'b0;
        vs_cnt = 0;
        for (int i = 0; i < 4 * HT * VT && vs_cnt < 2; i++) tick(1'b1);
        check("lock_early", {lk0, lk1}, 2'b00);
        for (int i = 0; i < 2 * HT * VT && vs_cnt < 3; i++) tick(1'b1);
        check("lock_rise", {lk0, lk1, hd0, vd0, hd1, vd1},
              {2'b11, 12'(0), 12'(VR), 12'(0), 12'(VR)});
        chk = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tick(1'b1);
        tick(1'b1);
        check("reset", {v0, v1}, 64'd0);
        rst_n = 1'b1;
        relock();
        for (int i = 0; i < 2 * HT * VT; i++) tick(1'b1);

        shift_line = 3;
        run_to(HR, 3);
        chk = 1'b0;
        tick(1'b1);
        check("hshift_err", {er0, er1, lk0, lk1}, 4'b1100);
        tick(1'b1);
        shift_line = -1;
        check("hshift_pulse", {er0, er1, lk0, lk1}, 4'b0000);
        relock();

        for (int i = 0; i < 4 * HT * VT; i++) tick(i % 4 == 0);
        for (int i = 0; i < 10; i++) tick(1'b0);

        run_to(4, 3);
        chk = 1'b0;
        rst_n = 1'b0;
        tick(1'b1);
        check("reset_mid", {v0, v1}, 64'd0);
        rst_n = 1'b1;
        relock();
        for (int i = 0; i < HT * VT; i++) tick(1'b1);

        run_to(0, VR);
        chk = 1'b0;
        drop = 1'b1;
        tick(1'b1);
        check("vs_drop_err", {er0, er1, lk0, lk1}, 4'b1100);
        run_to(0, VR + VS);
        drop = 1'b0;
        relock();
        for (int i = 0; i < HT * VT; i++) tick(1'b1);

        chk = 1'b0;
        ovr = 1'b1;
        ovr_hs = 1'b0;
        ovr_vs = 1'b0;
        tick(1'b1);
        ovr_hs = 1'b1;
        ovr_vs = 1'b1;
        tick(1'b1);
        check("dual_edge", {hd0, vd0, hd1, vd1}, {12'(HR), 12'(VR), 12'(HR), 12'(VR)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
